pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised next-PC generator for the 5-stage MIPS pipeline; owns the fetch PC register.
- Adds stall hold, exception redirect, ID-stage jump redirect and EX-stage branch resolution for beq/bne/blez/bgtz/bltz/bgez/jr.
- Includes a direct-mapped BTB with 2-bit counters for fetch-time prediction, plus mispredict recovery and a mispredict counter.

Parameters:
AW, 32, PC/address width
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_PC, 32'h0000_4180, exception handler entry
BTB_ENTRIES, 16, BTB depth; power of 2, >=2; IDX=log2(BTB_ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  hold IF (hazard unit)
exc_i  in  1  exception taken this cycle
id_jump_i  in  1  J/JAL decoded in ID
id_target_i  in  AW  J/JAL target
ex_valid_i  in  1  EX holds a valid control-flow instr
ex_br_type_i  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 jr
ex_zero_i  in  1  ALU result == 0
ex_neg_i  in  1  ALU result sign bit
ex_pc_i  in  AW  PC of EX instr
ex_target_i  in  AW  computed branch/jr target
ex_pred_taken_i  in  1  prediction carried from IF
ex_pred_target_i  in  AW  predicted target carried from IF
pc_o  out  AW  current fetch PC
pred_taken_o  out  1  BTB predicts taken for pc_o
pred_target_o  out  AW  predicted target for pc_o
flush_o  out  1  kill IF and ID (EX redirect or exception)
flush_if_o  out  1  kill IF only (accepted ID jump); also 1 whenever flush_o
mispredict_cnt_o  out  16  saturating mispredict count

Behaviour:
- Reset (async): pc_o=RESET_PC; mispredict_cnt_o=0; all BTB valid=0, counters=2'b01. pred_taken_o=0 and flushes=0 follow.
- Index = pc[IDX+1:2]; tag = pc[AW-1:IDX+2].
- Lookup is combinational on pc_o. pred_taken_o=1 iff entry valid, tag match and counter[1]=1. pred_target_o = entry target (0 on miss).
- actual_taken:
  - beq: zero; bne: !zero; blez: neg|zero; bgtz: !neg&!zero; bltz: neg; bgez: !neg; jr: 1; none: 0.
- mispredict = ex_valid_i & type!=0 & (actual_taken!=ex_pred_taken_i | (actual_taken & ex_target_i!=ex_pred_target_i)).
- Next PC at posedge clk, highest priority first:
  1. exc_i -> EXC_PC; flush_o=1.
  2. mispredict -> ex_target_i if actual_taken, else ex_pc_i+4; flush_o=1.
  3. id_jump_i & !stall_i -> id_target_i; flush_if_o=1.
  4. stall_i -> hold.
  5. pred_taken_o -> pred_target_o.
  6. pc_o+4, wrapping mod 2^AW.
- Redirects 1-2 override stall_i. An ID jump under stall is ignored; ID re-presents it next cycle.
- flush_o and flush_if_o are combinational in the same cycle as the redirect decision; the new PC is visible the next cycle (1-cycle redirect latency).
- BTB update at posedge clk when ex_valid_i & type!=0 & !exc_i, at index/tag of ex_pc_i:
  - hit: counter +1 (saturate 11) if taken, -1 (saturate 00) if not; target <= ex_target_i if taken.
  - miss & taken: allocate valid=1, tag, target, counter=2'b10.
  - miss & not taken: no write.
- Update occurs regardless of stall_i.
- Same-cycle lookup and update to the same index: lookup sees the pre-update contents.
- mispredict_cnt_o increments on each mispredict with !exc_i; holds at 16'hFFFF.
- rst asserted mid-operation: immediate return to the reset state; BTB contents are lost.

Test Plan:
- Reset then 3 clocks, no control -> pc_o 3000, 3004, 3008, 300C; pred_taken_o=0; flushes 0.
- EX beq ex_pc=3004, zero=1, pred 0, target=3040 -> flush_o=1; next pc_o=3040; cnt=1; BTB[1] valid, ctr=10. Refetch of 3004 -> pred_taken_o=1, pred_target_o=3040.
- Train the same bne not-taken twice from ctr=10 -> ctr 01 then 00. Second-pass fetch pred_taken_o=0. A predicted-taken, actually-not-taken case redirects to ex_pc+4.
- stall_i=1 with id_jump_i=1 (target 3100) for 2 cycles -> pc_o held, flush_if_o=0. Stall drops -> pc_o=3100 next cycle.
- exc_i and mispredict in the same cycle with stall_i=1 -> pc_o=4180; no BTB write; cnt unchanged.
- rst pulsed mid-run with pc_o=3040 -> pc_o=3000 immediately; lookup of 3004 misses; cnt=0.

Source files
------------

// File: rtl/pc_gen_if.sv
// Signal bundle between the fetch-PC generator and the rest of the pipeline.
// The slave side (pc_gen) consumes the hazard, exception, ID-jump and EX-resolution
// inputs, and it produces the fetch PC, the BTB prediction and the flush strobes.
//
// Qualifier semantics: there is no ready path. id_jump_i is accepted only in a
// cycle where stall_i is low; if it is refused, ID presents it again. The ex_*
// fields have meaning only while ex_valid_i is high. The outputs are valid in
// every cycle, and the flush strobes apply to the cycle in which they are high.
interface pc_gen_if #(
    parameter int AW = 32
);
    logic          stall_i;
    logic          exc_i;
    logic          id_jump_i;
    logic [AW-1:0] id_target_i;
    logic          ex_valid_i;
    logic [2:0]    ex_br_type_i;
    logic          ex_zero_i;
    logic          ex_neg_i;
    logic [AW-1:0] ex_pc_i;
    logic [AW-1:0] ex_target_i;
    logic          ex_pred_taken_i;
    logic [AW-1:0] ex_pred_target_i;
    logic [AW-1:0] pc_o;
    logic          pred_taken_o;
    logic [AW-1:0] pred_target_o;
    logic          flush_o;
    logic          flush_if_o;
    logic [15:0]   mispredict_cnt_o;

    modport master (
        output stall_i, exc_i, id_jump_i, id_target_i, ex_valid_i, ex_br_type_i,
               ex_zero_i, ex_neg_i, ex_pc_i, ex_target_i, ex_pred_taken_i, ex_pred_target_i,
        input  pc_o, pred_taken_o, pred_target_o, flush_o, flush_if_o, mispredict_cnt_o
    );

    modport slave (
        input  stall_i, exc_i, id_jump_i, id_target_i, ex_valid_i, ex_br_type_i,
               ex_zero_i, ex_neg_i, ex_pc_i, ex_target_i, ex_pred_taken_i, ex_pred_target_i,
        output pc_o, pred_taken_o, pred_target_o, flush_o, flush_if_o, mispredict_cnt_o
    );
endinterface

// File: rtl/pc_gen.sv
// Next-PC generator for the 5-stage MIPS pipeline. This module owns the fetch PC.
// It predicts with a direct-mapped BTB that holds 2-bit counters, it resolves
// branches in EX, it recovers from mispredicts, and it counts mispredicts with
// a saturating counter.
module pc_gen #(
    parameter int            AW          = 32,
    parameter logic [AW-1:0] RESET_PC    = 32'h0000_3000,
    parameter logic [AW-1:0] EXC_PC      = 32'h0000_4180,
    parameter int            BTB_ENTRIES = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = AW - IDX - 2;

    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLEZ = 3'b011;
    localparam logic [2:0] BR_BGTZ = 3'b100;
    localparam logic [2:0] BR_BLTZ = 3'b101;
    localparam logic [2:0] BR_BGEZ = 3'b110;
    localparam logic [2:0] BR_JR   = 3'b111;

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_next;
    logic [15:0]   cnt_q;

    logic          btb_valid  [BTB_ENTRIES];
    logic [TW-1:0] btb_tag    [BTB_ENTRIES];
    logic [AW-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]    btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0] f_idx;
    logic           f_hit;
    logic [IDX-1:0] u_idx;
    logic [TW-1:0]  u_tag;
    logic           u_hit;
    logic           is_branch;
    logic           actual_taken;
    logic           mispredict;
    logic           btb_upd;
    logic           unused_lsbs;

    // The two low PC bits are always zero on word-aligned fetch, so they never index or tag the BTB.
    assign unused_lsbs = ^{pc_q[1:0], bus.ex_pc_i[1:0]};

    // Fetch-time lookup on the current PC. It reads the pre-update contents of the BTB.
    assign f_idx             = pc_q[IDX+1:2];
    assign f_hit             = btb_valid[f_idx] && (btb_tag[f_idx] == pc_q[AW-1:IDX+2]);
    assign bus.pc_o          = pc_q;
    assign bus.pred_taken_o  = f_hit && btb_ctr[f_idx][1];
    assign bus.pred_target_o = f_hit ? btb_target[f_idx] : '0;

    // EX-stage lookup, done at the PC of the resolving instruction.
    assign u_idx = bus.ex_pc_i[IDX+1:2];
    assign u_tag = bus.ex_pc_i[AW-1:IDX+2];
    assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

    // Branch condition evaluated from the ALU flags.
    always_comb begin
        actual_taken = 1'b0;
        case (bus.ex_br_type_i)
            BR_BEQ:  actual_taken = bus.ex_zero_i;
            BR_BNE:  actual_taken = !bus.ex_zero_i;
            BR_BLEZ: actual_taken = bus.ex_neg_i || bus.ex_zero_i;
            BR_BGTZ: actual_taken = !bus.ex_neg_i && !bus.ex_zero_i;
            BR_BLTZ: actual_taken = bus.ex_neg_i;
            BR_BGEZ: actual_taken = !bus.ex_neg_i;
            BR_JR:   actual_taken = 1'b1;
            default: actual_taken = 1'b0;
        endcase
    end

    assign is_branch  = bus.ex_valid_i && (bus.ex_br_type_i != 3'b000);
    assign mispredict = is_branch &&
                        ((actual_taken != bus.ex_pred_taken_i) ||
                         (actual_taken && (bus.ex_target_i != bus.ex_pred_target_i)));
    assign btb_upd    = is_branch && !bus.exc_i;

    // A redirect from EX or from an exception kills both IF and ID. An accepted ID jump kills only IF.
    assign bus.flush_o    = bus.exc_i || mispredict;
    assign bus.flush_if_o = bus.flush_o || (bus.id_jump_i && !bus.stall_i);

    // Next-PC selection in priority order. Exception and mispredict redirects override a stall.
    always_comb begin
        pc_next = pc_q + AW'(4);
        if (bus.exc_i)
            pc_next = EXC_PC;
        else if (mispredict)
            pc_next = actual_taken ? bus.ex_target_i : bus.ex_pc_i + AW'(4);
        else if (bus.id_jump_i && !bus.stall_i)
            pc_next = bus.id_target_i;
        else if (bus.stall_i)
            pc_next = pc_q;
        else if (bus.pred_taken_o)
            pc_next = bus.pred_target_o;
    end

    // Fetch PC register and the saturating mispredict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q <= pc_next;
            if (mispredict && !bus.exc_i && (cnt_q != 16'hFFFF))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.mispredict_cnt_o = cnt_q;

    // BTB training from EX. This runs even under a stall, but it is suppressed in a cycle that takes an exception.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (btb_upd) begin
            if (u_hit) begin
                if (actual_taken) begin
                    if (btb_ctr[u_idx] != 2'b11)
                        btb_ctr[u_idx] <= btb_ctr[u_idx] + 2'b01;
                    btb_target[u_idx] <= bus.ex_target_i;
                end else if (btb_ctr[u_idx] != 2'b00) begin
                    btb_ctr[u_idx] <= btb_ctr[u_idx] - 2'b01;
                end
            end else if (actual_taken) begin
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= bus.ex_target_i;
                btb_ctr[u_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen. Each table row holds one cycle of stimulus and the
// outputs expected in that same cycle. A few hand-built sequences cover the
// mid-run reset, counter saturation, the same-index lookup/update case and PC wrap.
module tb_pc_gen;
    typedef struct {
        logic        stall;
        logic        exc;
        logic        jmp;
        logic [31:0] jtgt;
        logic        exv;
        logic [2:0]  bt;
        logic        zero;
        logic        neg;
        logic [31:0] expc;
        logic [31:0] extgt;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_fl;
        logic        e_fli;
        logic [15:0] e_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pc_gen_if #(.AW(32)) bus ();

    pc_gen #(
        .AW(32), .RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180), .BTB_ENTRIES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int stall, input int exc, input int jmp, input logic [31:0] jtgt,
                                input int exv, input int bt, input int zero, input int neg,
                                input logic [31:0] expc, input logic [31:0] extgt,
                                input int pt, input logic [31:0] ptgt,
                                input logic [31:0] e_pc, input int e_pt, input logic [31:0] e_ptgt,
                                input int e_fl, input int e_fli, input int e_cnt);
        vec_t v;
        v.stall = stall[0];  v.exc = exc[0];   v.jmp = jmp[0];   v.jtgt = jtgt;
        v.exv = exv[0];      v.bt = bt[2:0];   v.zero = zero[0]; v.neg = neg[0];
        v.expc = expc;       v.extgt = extgt;  v.pt = pt[0];     v.ptgt = ptgt;
        v.e_pc = e_pc;       v.e_pt = e_pt[0]; v.e_ptgt = e_ptgt;
        v.e_fl = e_fl[0];    v.e_fli = e_fli[0]; v.e_cnt = e_cnt[15:0];
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h, expected %h", name, id, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.stall_i          = v.stall;
        bus.exc_i            = v.exc;
        bus.id_jump_i        = v.jmp;
        bus.id_target_i      = v.jtgt;
        bus.ex_valid_i       = v.exv;
        bus.ex_br_type_i     = v.bt;
        bus.ex_zero_i        = v.zero;
        bus.ex_neg_i         = v.neg;
        bus.ex_pc_i          = v.expc;
        bus.ex_target_i      = v.extgt;
        bus.ex_pred_taken_i  = v.pt;
        bus.ex_pred_target_i = v.ptgt;
    endtask

    task automatic check_outs(input vec_t v, input int id);
        check("pc_o", id, bus.pc_o, v.e_pc);
        check("pred_taken_o", id, {31'd0, bus.pred_taken_o}, {31'd0, v.e_pt});
        check("pred_target_o", id, bus.pred_target_o, v.e_ptgt);
        check("flush_o", id, {31'd0, bus.flush_o}, {31'd0, v.e_fl});
        check("flush_if_o", id, {31'd0, bus.flush_if_o}, {31'd0, v.e_fli});
        check("mispredict_cnt_o", id, {16'd0, bus.mispredict_cnt_o}, {16'd0, v.e_cnt});
    endtask

    // Drive just after a rising edge, compare on the falling edge, and return just after the next rising edge.
    task automatic run_vec(input vec_t v, input int id);
        drive(v);
        @(negedge clk);
        check_outs(v, id);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[28];
    vec_t seq_a[4];
    vec_t seq_b[10];
    vec_t idle_v;

    // Stimulus, the scoreboard, and the final report.
    initial begin
        n_pass  = 0;
        n_total = 0;
        idle_v  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 32'h3000,0,0,0,0,0);

        //          stl exc jmp jtgt        exv bt zero neg ex_pc        ex_tgt       pt pt_tgt       | pc           pt ptgt        fl fli cnt
        tbl[0]  = mk(0,0,0,0,               0,0,0,0, 0,0,0,0,                                         32'h3000,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,               0,0,0,0, 0,0,0,0,                                         32'h3004,0,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,               0,0,0,0, 0,0,0,0,                                         32'h3008,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,               1,1,1,0, 32'h3004,32'h3040,0,0,                           32'h300C,0,0,1,1,0);
        tbl[4]  = mk(0,0,1,32'h3004,        0,0,0,0, 0,0,0,0,                                         32'h3040,0,0,0,1,1);
        tbl[5]  = mk(0,0,0,0,               0,0,0,0, 0,0,0,0,                                         32'h3004,1,32'h3040,0,0,1);
        tbl[6]  = mk(0,0,0,0,               1,2,1,0, 32'h3004,32'h3040,1,32'h3040,                    32'h3040,0,0,1,1,1);
        tbl[7]  = mk(0,0,0,0,               1,2,1,0, 32'h3004,32'h3040,0,0,                           32'h3008,0,0,0,0,2);
        tbl[8]  = mk(0,0,1,32'h3004,        0,0,0,0, 0,0,0,0,                                         32'h300C,0,0,0,1,2);
        tbl[9]  = mk(0,0,0,0,               0,0,0,0, 0,0,0,0,                                         32'h3004,0,32'h3040,0,0,2);
        tbl[10] = mk(0,0,0,0,               1,1,1,0, 32'h3004,32'h3040,0,0,                           32'h3008,0,0,1,1,2);
        tbl[11] = mk(0,0,1,32'h3004,        0,0,0,0, 0,0,0,0,                                         32'h3040,0,0,0,1,3);
        tbl[12] = mk(0,0,0,0,               0,0,0,0, 0,0,0,0,                                         32'h3004,0,32'h3040,0,0,3);
        tbl[13] = mk(1,0,1,32'h3100,        0,0,0,0, 0,0,0,0,                                         32'h3008,0,0,0,0,3);
        tbl[14] = mk(1,0,1,32'h3100,        0,0,0,0, 0,0,0,0,                                         32'h3008,0,0,0,0,3);
        tbl[15] = mk(0,0,1,32'h3100,        0,0,0,0, 0,0,0,0,                                         32'h3008,0,0,0,1,3);
        tbl[16] = mk(1,1,0,0,               1,1,1,0, 32'h3010,32'h3200,0,0,                           32'h3100,0,0,1,1,3);
        tbl[17] = mk(0,0,1,32'h3010,        0,0,0,0, 0,0,0,0,                                         32'h4180,0,0,0,1,3);
        tbl[18] = mk(0,0,1,32'h3040,        0,0,0,0, 0,0,0,0,                                         32'h3010,0,0,0,1,3);
        tbl[19] = mk(0,0,0,0,               0,0,0,0, 0,0,0,0,                                         32'h3040,0,0,0,0,3);
        tbl[20] = mk(0,0,0,0,               1,3,0,0, 32'h10020,32'h3400,0,0,                          32'h3044,0,0,0,0,3);
        tbl[21] = mk(0,0,0,0,               1,3,0,1, 32'h10024,32'h3400,1,32'h3400,                   32'h3048,0,0,0,0,3);
        tbl[22] = mk(0,0,0,0,               1,4,0,0, 32'h10028,32'h3400,0,0,                          32'h304C,0,0,1,1,3);
        tbl[23] = mk(0,0,0,0,               1,5,0,0, 32'h10030,32'h3400,1,32'h3400,                   32'h3400,0,0,1,1,4);
        tbl[24] = mk(0,0,0,0,               1,6,0,1, 32'h10038,32'h3400,0,0,                          32'h10034,0,0,0,0,5);
        tbl[25] = mk(0,0,0,0,               1,7,0,0, 32'h1003C,32'h3600,1,32'h3500,                   32'h10038,0,0,1,1,5);
        tbl[26] = mk(0,0,0,0,               0,0,0,0, 0,0,0,0,                                         32'h3600,0,0,0,0,6);
        tbl[27] = mk(0,0,0,0,               1,0,0,0, 32'h3100,32'h3300,1,32'h1234,                    32'h3604,0,0,0,0,6);

        // Mid-run reset: move to 3040, pulse rst, then confirm that the BTB entry for 3004 is gone.
        seq_a[0] = mk(0,0,1,32'h3040,       0,0,0,0, 0,0,0,0,                                         32'h3608,0,0,0,1,6);
        seq_a[1] = mk(0,0,0,0,              0,0,0,0, 0,0,0,0,                                         32'h3040,0,0,0,0,6);
        seq_a[2] = mk(0,0,0,0,              0,0,0,0, 0,0,0,0,                                         32'h3000,0,0,0,0,0);
        seq_a[3] = mk(0,0,0,0,              0,0,0,0, 0,0,0,0,                                         32'h3004,0,0,0,0,0);

        // Counter saturation at 11, a lookup and an update to the same index in one cycle, and PC wrap.
        seq_b[0] = mk(0,0,0,0,              1,1,1,0, 32'h3020,32'h3080,0,0,                           32'h3008,0,0,1,1,0);
        seq_b[1] = mk(0,0,0,0,              1,1,1,0, 32'h3020,32'h3080,1,32'h3080,                    32'h3080,0,0,0,0,1);
        seq_b[2] = mk(0,0,0,0,              1,1,1,0, 32'h3020,32'h3080,1,32'h3080,                    32'h3084,0,0,0,0,1);
        seq_b[3] = mk(0,0,0,0,              1,1,0,0, 32'h3020,32'h3080,1,32'h3080,                    32'h3088,0,0,1,1,1);
        seq_b[4] = mk(0,0,1,32'h3020,       0,0,0,0, 0,0,0,0,                                         32'h3024,0,0,0,1,2);
        seq_b[5] = mk(0,0,0,0,              1,2,1,0, 32'h3020,32'h3080,1,32'h3080,                    32'h3020,1,32'h3080,1,1,2);
        seq_b[6] = mk(0,0,1,32'h3020,       0,0,0,0, 0,0,0,0,                                         32'h3024,0,0,0,1,3);
        seq_b[7] = mk(0,0,1,32'hFFFF_FFFC,  0,0,0,0, 0,0,0,0,                                         32'h3020,0,32'h3080,0,1,3);
        seq_b[8] = mk(0,0,0,0,              0,0,0,0, 0,0,0,0,                                         32'hFFFF_FFFC,0,0,0,0,3);
        seq_b[9] = mk(0,0,0,0,              0,0,0,0, 0,0,0,0,                                         32'h0000_0000,0,0,0,0,3);

        // Reset state check while rst is still held.
        rst = 1'b1;
        drive(idle_v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs(idle_v, -1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 28; i++) run_vec(tbl[i], i);

        run_vec(seq_a[0], 100);
        run_vec(seq_a[1], 101);
        // Asynchronous reset in the middle of a cycle must take effect without waiting for a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", 102, bus.pc_o, 32'h3000);
        check("async_rst_cnt", 102, {16'd0, bus.mispredict_cnt_o}, 32'd0);
        check("async_rst_flush", 102, {31'd0, bus.flush_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(seq_a[2], 103);
        run_vec(seq_a[3], 104);

        for (int i = 0; i < 10; i++) run_vec(seq_b[i], 200 + i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
